// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Sequences a main/side intersection with a pedestrian walk phase and an
// emergency preempt. Every timed state is driven by one 32-bit down-counter
// loaded with dwell-1 on entry. A state whose counter reads zero has run its
// full dwell.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   car      in   side-road car present (level)
//   ped_req  in   pedestrian button (pulse or level), latched into ped_pend
//   emerg    in   emergency preempt (level)
//   light    out  {main R,Y,G, side R,Y,G}, registered
//   walk     out  pedestrian walk lamp, registered
//   ped_ack  out  one-cycle pulse on walk-phase entry
//   phase    out  current state code
//
// state | meaning
// MG  0 | main green, untimed hold after GREEN_MIN
// MY  1 | main yellow
// AR1 2 | all-red before side/walk service
// SG  3 | side green
// SY  4 | side yellow
// AR2 5 | all-red before returning to main (or emergency)
// PW  6 | pedestrian walk, all vehicle lamps red
// EM  7 | emergency hold, all red while emerg=1
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int SIDE_T    = 6,
  parameter int WALK_T    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [5:0] light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5,
    PW  = 3'd6,
    EM  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        ped_pend_q, ped_pend_d;
  logic        last_ped_q, last_ped_d;   // 1: pedestrian was served last
  logic [5:0]  light_q, light_d;
  logic        walk_q, walk_d;
  logic        ped_ack_q, ped_ack_d;
  logic        expired;
  logic        entering;
  logic        enter_pw;

  assign expired  = (timer_q == 32'd0);
  assign entering = (state_d != state_q);
  assign enter_pw = entering && (state_d == PW);

  always_comb begin
    state_d = state_q;
    case (state_q)
      MG: begin
        if (emerg)                              state_d = EM;
        else if (expired && (car || ped_pend_q)) state_d = MY;
      end
      MY:  if (expired) state_d = AR1;
      AR1: begin
        if (expired) begin
          if (emerg)                    state_d = EM;
          else if (car && ped_pend_q)   state_d = last_ped_q ? SG : PW;
          else if (car)                 state_d = SG;
          else if (ped_pend_q)          state_d = PW;
          else                          state_d = MG;
        end
      end
      // Emergency cuts side green short but still clears through yellow.
      SG:  if (emerg || expired) state_d = SY;
      SY:  if (expired) state_d = AR2;
      AR2: if (expired) state_d = emerg ? EM : MG;
      // The walk always completes; with emerg it skips the second all-red.
      PW:  if (expired) state_d = emerg ? EM : AR2;
      EM:  if (!emerg) state_d = MG;
      default: state_d = MG;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (entering) begin
      case (state_d)
        MG:       timer_d = 32'(GREEN_MIN - 1);
        MY, SY:   timer_d = 32'(YELLOW_T - 1);
        AR1, AR2: timer_d = 32'(ALLRED_T - 1);
        SG:       timer_d = 32'(SIDE_T - 1);
        PW:       timer_d = 32'(WALK_T - 1);
        default:  timer_d = 32'd0;
      endcase
    end else if (!expired) begin
      timer_d = timer_q - 32'd1;
    end
  end

  always_comb begin
    last_ped_d = last_ped_q;
    if (entering && state_d == SG) last_ped_d = 1'b0;
    if (enter_pw)                  last_ped_d = 1'b1;
    // A press during the walk itself is held for the next service.
    ped_pend_d = enter_pw ? 1'b0 : (ped_pend_q | ped_req);
    ped_ack_d  = enter_pw;
    walk_d     = (state_d == PW);
    case (state_d)
      MG:      light_d = 6'b001100;
      MY:      light_d = 6'b010100;
      SG:      light_d = 6'b100001;
      SY:      light_d = 6'b100010;
      default: light_d = 6'b100100;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MG;
      timer_q    <= 32'(GREEN_MIN - 1);
      ped_pend_q <= 1'b0;
      last_ped_q <= 1'b1;
      light_q    <= 6'b001100;
      walk_q     <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      last_ped_q <= last_ped_d;
      light_q    <= light_d;
      walk_q     <= walk_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  assign light   = light_q;
  assign walk    = walk_q;
  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       car = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic [5:0] light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  int total = 0;
  int bad = 0;
  logic [10:0] sb[$];

  localparam logic [2:0] C_MG = 3'd0, C_MY = 3'd1, C_AR1 = 3'd2, C_SG = 3'd3,
                         C_SY = 3'd4, C_AR2 = 3'd5, C_PW = 3'd6, C_EM = 3'd7;

  traffic_phase_scheduler dut (
    .clk(clk), .rst_n(rst_n), .car(car), .ped_req(ped_req), .emerg(emerg),
    .light(light), .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] exp_word(input logic [2:0] ph, input logic ack);
    logic [5:0] l;
    case (ph)
      C_MG:    l = 6'b001100;
      C_MY:    l = 6'b010100;
      C_SG:    l = 6'b100001;
      C_SY:    l = 6'b100010;
      default: l = 6'b100100;
    endcase
    return {l, (ph == C_PW), ack, ph};
  endfunction

  task automatic push(input logic [2:0] ph, input int n, input logic ack);
    for (int i = 0; i < n; i++) sb.push_back(exp_word(ph, ack));
  endtask

  task automatic check_now(input string tag);
    logic [10:0] exp_v;
    logic [10:0] obs_v;
    total++;
    obs_v = {light, walk, ped_ack, phase};
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty obs=%h", tag, obs_v);
    end else begin
      exp_v = sb.pop_front();
      assert (obs_v === exp_v)
      else begin
        bad++;
        $error("FAIL %s obs{light,walk,ack,phase}=%b exp=%b t=%0t", tag, obs_v, exp_v, $time);
      end
    end
  endtask

  task automatic check_n(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_now(tag);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; car = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    #1;
    sb.delete();
    push(C_MG, 1, 1'b0);
    check_now("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // idle: 100 cycles with no requests
    do_reset();
    push(C_MG, 100, 1'b0);
    check_n(100, "idle");

    // car request: timing of the full side cycle
    do_reset();
    check_n(0, "none");
    push(C_MG, 1, 1'b0);
    check_n(1, "car_mg1");
    car = 1'b1;
    push(C_MG, 6, 1'b0); push(C_MY, 3, 1'b0); push(C_AR1, 2, 1'b0);
    push(C_SG, 6, 1'b0); push(C_SY, 3, 1'b0); push(C_AR2, 2, 1'b0);
    push(C_MG, 8, 1'b0);
    check_n(12, "car_to_sg");
    car = 1'b0;
    check_n(18, "car_rest");

    // pedestrian pulse
    do_reset();
    push(C_MG, 1, 1'b0);
    check_n(1, "ped_mg1");
    ped_req = 1'b1;
    push(C_MG, 1, 1'b0);
    check_n(1, "ped_mg2");
    ped_req = 1'b0;
    push(C_MG, 5, 1'b0); push(C_MY, 3, 1'b0); push(C_AR1, 2, 1'b0);
    push(C_PW, 1, 1'b1); push(C_PW, 4, 1'b0); push(C_AR2, 2, 1'b0);
    push(C_MG, 20, 1'b0);
    check_n(37, "ped_walk");

    // car and ped both pending: car first, then ped
    do_reset();
    push(C_MG, 1, 1'b0);
    check_n(1, "both_mg1");
    car = 1'b1; ped_req = 1'b1;
    push(C_MG, 1, 1'b0);
    check_n(1, "both_mg2");
    ped_req = 1'b0;
    push(C_MG, 5, 1'b0); push(C_MY, 3, 1'b0); push(C_AR1, 2, 1'b0);
    push(C_SG, 6, 1'b0); push(C_SY, 3, 1'b0); push(C_AR2, 2, 1'b0);
    push(C_MG, 8, 1'b0); push(C_MY, 3, 1'b0); push(C_AR1, 2, 1'b0);
    push(C_PW, 1, 1'b1); push(C_PW, 4, 1'b0); push(C_AR2, 2, 1'b0);
    check_n(41, "both_seq");
    car = 1'b0;
    push(C_MG, 10, 1'b0);
    check_n(10, "both_tail");

    // emergency raised mid side-green
    do_reset();
    push(C_MG, 1, 1'b0);
    check_n(1, "em_mg1");
    car = 1'b1;
    push(C_MG, 6, 1'b0); push(C_MY, 3, 1'b0); push(C_AR1, 2, 1'b0);
    push(C_SG, 1, 1'b0);
    check_n(12, "em_to_sg");
    car = 1'b0;
    push(C_SG, 1, 1'b0);
    check_n(1, "em_sg");
    emerg = 1'b1;
    push(C_SY, 3, 1'b0); push(C_AR2, 2, 1'b0); push(C_EM, 5, 1'b0);
    check_n(10, "em_preempt");
    emerg = 1'b0; car = 1'b1;
    push(C_MG, 8, 1'b0); push(C_MY, 1, 1'b0);
    check_n(9, "em_release");
    car = 1'b0;

    // reset pulsed during walk
    do_reset();
    push(C_MG, 1, 1'b0);
    check_n(1, "rstpw_mg1");
    ped_req = 1'b1;
    push(C_MG, 1, 1'b0);
    check_n(1, "rstpw_mg2");
    ped_req = 1'b0;
    push(C_MG, 5, 1'b0); push(C_MY, 3, 1'b0); push(C_AR1, 2, 1'b0);
    push(C_PW, 1, 1'b1); push(C_PW, 1, 1'b0);
    check_n(12, "rstpw_to_pw");
    #2;
    rst_n = 1'b0;
    #1;
    push(C_MG, 1, 1'b0);
    check_now("rstpw_async");
    @(negedge clk);
    rst_n = 1'b1;
    push(C_MG, 25, 1'b0);
    check_n(25, "rstpw_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
